// File: rtl/io_pkg.sv
// Shared definitions for the I/O port bridge: default word width, FIFO depth
// and the occupancy-counter width helper.
package io_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 4;

  // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Show-ahead synchronous FIFO. Requests are gated internally against
// full/empty; a single error hook reports either a rejected push or a
// rejected pop, selected by ERR_ON_POP.
module io_sync_fifo
  import io_pkg::*;
#(
  parameter int WIDTH      = IO_WIDTH,
  parameter int DEPTH      = IO_DEPTH,
  parameter int ERR_ON_POP = 0
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      wr_req,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_req,
  output logic [WIDTH-1:0]          rd_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      err_hook
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Full/empty come straight from the registered count, so a pop can never
  // make room for a push in the same cycle.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = wr_req & ~full;
  assign rd_en    = rd_req & ~empty;
  assign rd_data  = mem[rd_ptr];
  assign err_hook = (ERR_ON_POP != 0) ? (rd_req & empty) : (wr_req & full);

  // Storage write; contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// Device-side bridge for the core's read_in / write_out ports: an inbound
// FIFO fed by the host and drained by the core, and an outbound FIFO fed by
// the core's write strobe and drained by the host.
module io_port_bridge
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          host_in_data,
  input  logic                      host_in_valid,
  output logic                      host_in_ready,
  output logic [WIDTH-1:0]          read_in,
  output logic                      cpu_in_avail,
  input  logic                      cpu_read_pop,
  input  logic [WIDTH-1:0]          write_out,
  input  logic                      cpu_write_strobe,
  output logic                      cpu_out_full,
  output logic [WIDTH-1:0]          host_out_data,
  output logic                      host_out_valid,
  input  logic                      host_out_ready,
  output logic [cnt_w(DEPTH)-1:0]   in_count,
  output logic [cnt_w(DEPTH)-1:0]   out_count,
  output logic                      overflow_err,
  output logic                      underflow_err
);

  logic [WIDTH-1:0] in_head;
  logic [WIDTH-1:0] out_head;
  logic             in_full;
  logic             in_empty;
  logic             out_full;
  logic             out_empty;
  logic             in_pop_rej;
  logic             out_push_rej;

  io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_ON_POP(1)) u_in_fifo (
    .clock    (clock),
    .rst      (rst),
    .wr_req   (host_in_valid),
    .wr_data  (host_in_data),
    .rd_req   (cpu_read_pop),
    .rd_data  (in_head),
    .count    (in_count),
    .full     (in_full),
    .empty    (in_empty),
    .err_hook (in_pop_rej)
  );

  io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_ON_POP(0)) u_out_fifo (
    .clock    (clock),
    .rst      (rst),
    .wr_req   (cpu_write_strobe),
    .wr_data  (write_out),
    .rd_req   (host_out_ready),
    .rd_data  (out_head),
    .count    (out_count),
    .full     (out_full),
    .empty    (out_empty),
    .err_hook (out_push_rej)
  );

  // Head words are forced to zero while their FIFO is empty so stale RAM never leaks out.
  assign host_in_ready  = ~in_full;
  assign cpu_in_avail   = ~in_empty;
  assign read_in        = in_empty ? '0 : in_head;
  assign cpu_out_full   = out_full;
  assign host_out_valid = ~out_empty;
  assign host_out_data  = out_empty ? '0 : out_head;

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (out_push_rej) overflow_err  <= 1'b1;
      if (in_pop_rej)   underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: a queue-based model plus a per-cycle compare
// process, with directed scenarios and literal checks.
module tb_io_port_bridge;

  localparam int W = 16;
  localparam int D = 4;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  host_in_data = '0;
  logic          host_in_valid = 1'b0;
  logic          host_in_ready;
  logic [W-1:0]  read_in;
  logic          cpu_in_avail;
  logic          cpu_read_pop = 1'b0;
  logic [W-1:0]  write_out = '0;
  logic          cpu_write_strobe = 1'b0;
  logic          cpu_out_full;
  logic [W-1:0]  host_out_data;
  logic          host_out_valid;
  logic          host_out_ready = 1'b0;
  logic [2:0]    in_count;
  logic [2:0]    out_count;
  logic          overflow_err;
  logic          underflow_err;

  int total_checks = 0;
  int passed_checks = 0;

  io_port_bridge #(.WIDTH(W), .DEPTH(D)) dut (
    .clock            (clock),
    .rst              (rst),
    .host_in_data     (host_in_data),
    .host_in_valid    (host_in_valid),
    .host_in_ready    (host_in_ready),
    .read_in          (read_in),
    .cpu_in_avail     (cpu_in_avail),
    .cpu_read_pop     (cpu_read_pop),
    .write_out        (write_out),
    .cpu_write_strobe (cpu_write_strobe),
    .cpu_out_full     (cpu_out_full),
    .host_out_data    (host_out_data),
    .host_out_valid   (host_out_valid),
    .host_out_ready   (host_out_ready),
    .in_count         (in_count),
    .out_count        (out_count),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: two word queues and two sticky flags.
  logic [W-1:0] inq[$];
  logic [W-1:0] outq[$];
  bit           m_ovf;
  bit           m_unf;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      inq.delete();
      outq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      bit in_push, in_pop, out_push, out_pop;
      in_push  = host_in_valid && (inq.size() < D);
      in_pop   = cpu_read_pop && (inq.size() > 0);
      out_push = cpu_write_strobe && (outq.size() < D);
      out_pop  = host_out_ready && (outq.size() > 0);
      if (cpu_read_pop && inq.size() == 0) m_unf = 1'b1;
      if (cpu_write_strobe && outq.size() == D) m_ovf = 1'b1;
      if (in_pop) void'(inq.pop_front());
      if (in_push) inq.push_back(host_in_data);
      if (out_pop) void'(outq.pop_front());
      if (out_push) outq.push_back(write_out);
    end
  end

  // Every cycle, away from the active edge, compare all outputs with the model.
  always @(negedge clock) begin
    check("in_count", 32'(in_count), 32'(inq.size()));
    check("out_count", 32'(out_count), 32'(outq.size()));
    check("read_in", 32'(read_in), 32'((inq.size() > 0) ? inq[0] : '0));
    check("host_out_data", 32'(host_out_data), 32'((outq.size() > 0) ? outq[0] : '0));
    check("host_in_ready", 32'(host_in_ready), 32'(inq.size() < D));
    check("cpu_in_avail", 32'(cpu_in_avail), 32'(inq.size() > 0));
    check("cpu_out_full", 32'(cpu_out_full), 32'(outq.size() == D));
    check("host_out_valid", 32'(host_out_valid), 32'(outq.size() > 0));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    check("underflow_err", 32'(underflow_err), 32'(m_unf));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [W-1:0] seq [10];
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(host_in_ready), 32'd1);
    check("rst_out_valid", 32'(host_out_valid), 32'd0);

    // 1. Reset in the middle of a stream
    host_in_valid = 1'b1; host_in_data = 16'hBEEF; tick();
    host_in_data = 16'hBEE0; tick();
    host_in_valid = 1'b0;
    check("t1_count2", 32'(in_count), 32'd2);
    check("t1_head", 32'(read_in), 32'hBEEF);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_count", 32'(in_count), 32'd0);
    check("t1_rst_read_in", 32'(read_in), 32'd0);
    check("t1_rst_ready", 32'(host_in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // 2. Inbound ordering through a full FIFO
    for (int i = 0; i < 4; i++) begin
      host_in_valid = 1'b1;
      host_in_data = 16'h1111 * 16'(i + 1);
      tick();
    end
    host_in_valid = 1'b0;
    check("t2_full_ready", 32'(host_in_ready), 32'd0);
    check("t2_count4", 32'(in_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_order", 32'(read_in), 32'h1111 * 32'(i + 1));
      cpu_read_pop = 1'b1;
      tick();
    end
    cpu_read_pop = 1'b0;
    check("t2_empty_read_in", 32'(read_in), 32'd0);

    // 3. Outbound fill, overflow and drain
    host_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_write_strobe = 1'b1;
      write_out = 16'hA000 + 16'(i);
      tick();
      if (i == 3) check("t3_full_after4", 32'(cpu_out_full), 32'd1);
    end
    cpu_write_strobe = 1'b0;
    check("t3_overflow", 32'(overflow_err), 32'd1);
    host_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain", 32'(host_out_data), 32'hA000 + 32'(i));
      tick();
    end
    host_out_ready = 1'b0;
    check("t3_no_A004", 32'(host_out_valid), 32'd0);
    check("t3_data_zero", 32'(host_out_data), 32'd0);

    // 4. Underflow on an empty inbound FIFO
    check("t4_unf_before", 32'(underflow_err), 32'd0);
    cpu_read_pop = 1'b1; tick();
    cpu_read_pop = 1'b0;
    check("t4_count0", 32'(in_count), 32'd0);
    check("t4_unf_set", 32'(underflow_err), 32'd1);
    tick(); tick();
    check("t4_unf_held", 32'(underflow_err), 32'd1);

    // 5. Concurrent push+pop at count 2 across pointer wrap
    seq[0] = 16'h0001; seq[1] = 16'h0002;
    for (int i = 0; i < 8; i++) seq[i + 2] = 16'h5550 + 16'(i);
    host_in_valid = 1'b1;
    host_in_data = seq[0]; tick();
    host_in_data = seq[1]; tick();
    for (int i = 0; i < 8; i++) begin
      check("t5_head", 32'(read_in), 32'(seq[i]));
      host_in_data = seq[i + 2];
      cpu_read_pop = 1'b1;
      tick();
      check("t5_count2", 32'(in_count), 32'd2);
    end
    host_in_valid = 1'b0;
    check("t5_tail0", 32'(read_in), 32'h5556);
    tick();
    check("t5_tail1", 32'(read_in), 32'h5557);
    tick();
    cpu_read_pop = 1'b0;
    check("t5_empty", 32'(in_count), 32'd0);

    // 6. Push and pop together on an empty FIFO
    host_in_valid = 1'b1; host_in_data = 16'h7777; cpu_read_pop = 1'b1;
    tick();
    host_in_valid = 1'b0; cpu_read_pop = 1'b0;
    check("t6_count1", 32'(in_count), 32'd1);
    check("t6_read_in", 32'(read_in), 32'h7777);
    check("t6_unf", 32'(underflow_err), 32'd1);
    tick();

    // Reset clears sticky flags
    #2 rst = 1'b1;
    #1;
    check("final_ovf_clr", 32'(overflow_err), 32'd0);
    check("final_unf_clr", 32'(underflow_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
